// File: rtl/dmem_ctrl.sv
// dmem_ctrl: data-memory access controller between the pipeline memory stage and a
// single-port SRAM. It handles byte/half/word loads and stores, detects misalignment,
// extends load data and aborts accesses the SRAM never acknowledges.
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   req_read/req_write, req_addr, req_wdata, req_size, req_unsigned
//                     memory-stage request, held stable while mem_stall=1
//   mem_stall         combinational pipeline hold
//   rdata, done, misalign_err, timeout_err
//                     completion pulse with load data and error qualifiers
//   sram_req/we/addr/be/wdata, sram_ack/rdata
//                     SRAM request/acknowledge port (word addressed)
//
// Optional feature: define DMEM_CTRL_WBUF_EN to add a one-entry posted write buffer.
module dmem_ctrl #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_read,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  output logic        mem_stall,
  output logic [31:0] rdata,
  output logic        done,
  output logic        misalign_err,
  output logic        timeout_err,
  output logic        sram_req,
  output logic        sram_we,
  output logic [29:0] sram_addr,
  output logic [3:0]  sram_be,
  output logic [31:0] sram_wdata,
  input  logic        sram_ack,
  input  logic [31:0] sram_rdata
);

  typedef enum logic [1:0] {StIdle, StAccess, StDone} state_e;

  localparam logic [9:0] TimeoutLast = 10'(TIMEOUT - 1);

  state_e      state_q, state_d;
  logic [9:0]  cnt_q;
  logic [29:0] addr_q;
  logic [1:0]  off_q;
  logic [1:0]  size_q;
  logic        uns_q;
  logic        we_q;
  logic [3:0]  be_q;
  logic [31:0] wdata_q;
  logic [31:0] rdata_q;
  logic        mis_q;
  logic        tmo_q;

  logic        is_req;
  logic        misaligned;
  logic [3:0]  be_c;
  logic [31:0] wdata_c;
  logic        accept;
  logic        timed_out;
  logic        wb_capture;
  logic        wb_block;
  logic [31:0] lane;
  logic [31:0] load_ext;

  assign is_req     = req_read | req_write;
  // Size 11 is treated as a word, so any size with bit 1 set needs word alignment.
  assign misaligned = ((req_size == 2'b01) && req_addr[0]) ||
                      (req_size[1] && (req_addr[1:0] != 2'b00));
  assign timed_out  = (cnt_q == TimeoutLast);

  always_comb begin
    be_c    = 4'b1111;
    wdata_c = req_wdata;
    unique case (req_size)
      2'b00: begin
        be_c    = 4'b0001 << req_addr[1:0];
        wdata_c = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        be_c    = 4'b0011 << req_addr[1:0];
        wdata_c = {2{req_wdata[15:0]}};
      end
      default: ;
    endcase
  end

  // Load lane selection and extension from the captured request.
  assign lane = sram_rdata >> {off_q, 3'b000};
  always_comb begin
    load_ext = lane;
    unique case (size_q)
      2'b00:   load_ext = uns_q ? {24'b0, lane[7:0]} : {{24{lane[7]}}, lane[7:0]};
      2'b01:   load_ext = uns_q ? {16'b0, lane[15:0]} : {{16{lane[15]}}, lane[15:0]};
      default: ;
    endcase
  end

`ifdef DMEM_CTRL_WBUF_EN
  logic        wb_valid_q;
  logic        wb_done_q;
  logic [29:0] wb_addr_q;
  logic [3:0]  wb_be_q;
  logic [31:0] wb_wdata_q;

  assign wb_capture = (state_q == StIdle) && req_write && !misaligned && !wb_valid_q;
  // While the buffer drains it owns the SRAM port; only misaligned stores bypass it.
  assign wb_block   = wb_valid_q && (req_read || !misaligned);
  assign done       = (state_q == StDone) | wb_done_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_valid_q <= 1'b0;
      wb_done_q  <= 1'b0;
      wb_addr_q  <= '0;
      wb_be_q    <= '0;
      wb_wdata_q <= '0;
    end else begin
      wb_done_q <= wb_capture;
      if (wb_capture) begin
        wb_valid_q <= 1'b1;
        wb_addr_q  <= req_addr[31:2];
        wb_be_q    <= be_c;
        wb_wdata_q <= wdata_c;
      end else if (wb_valid_q && sram_ack) begin
        wb_valid_q <= 1'b0;
      end
    end
  end
`else
  assign wb_capture = 1'b0;
  assign wb_block   = 1'b0;
  assign done       = (state_q == StDone);
`endif

  assign accept = (state_q == StIdle) && is_req && !wb_block && !wb_capture;

  always_comb begin
    state_d   = state_q;
    mem_stall = 1'b0;
    unique case (state_q)
      StIdle: begin
        mem_stall = is_req && !wb_capture;
        if (accept) state_d = misaligned ? StDone : StAccess;
      end
      StAccess: begin
        mem_stall = 1'b1;
        if (sram_ack || timed_out) state_d = StDone;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    sram_req   = (state_q == StAccess);
    sram_we    = (state_q == StAccess) && we_q;
    sram_be    = (state_q == StAccess) ? be_q : 4'b0000;
    sram_addr  = addr_q;
    sram_wdata = wdata_q;
`ifdef DMEM_CTRL_WBUF_EN
    if (wb_valid_q) begin
      sram_req   = 1'b1;
      sram_we    = 1'b1;
      sram_be    = wb_be_q;
      sram_addr  = wb_addr_q;
      sram_wdata = wb_wdata_q;
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      addr_q  <= '0;
      off_q   <= '0;
      size_q  <= '0;
      uns_q   <= 1'b0;
      we_q    <= 1'b0;
      be_q    <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      mis_q   <= 1'b0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        cnt_q   <= '0;
        addr_q  <= req_addr[31:2];
        off_q   <= req_addr[1:0];
        size_q  <= req_size;
        uns_q   <= req_unsigned;
        we_q    <= req_write;
        be_q    <= be_c;
        wdata_q <= wdata_c;
        rdata_q <= '0;
        mis_q   <= misaligned;
        tmo_q   <= 1'b0;
      end else if (state_q == StAccess) begin
        cnt_q <= cnt_q + 10'd1;
        if (sram_ack) begin
          if (!we_q) rdata_q <= load_ext;
        end else if (timed_out) begin
          tmo_q <= 1'b1;
        end
      end
    end
  end

  assign rdata        = rdata_q;
  assign misalign_err = (state_q == StDone) && mis_q;
  assign timeout_err  = (state_q == StDone) && tmo_q;

endmodule

// File: tb/tb_dmem_ctrl.sv
module tb_dmem_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_read, req_write, req_unsigned;
  logic [31:0] req_addr, req_wdata;
  logic [1:0]  req_size;
  logic        mem_stall, done, misalign_err, timeout_err;
  logic [31:0] rdata;
  logic        sram_req, sram_we, sram_ack;
  logic [29:0] sram_addr;
  logic [3:0]  sram_be;
  logic [31:0] sram_wdata, sram_rdata;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  dmem_ctrl #(.TIMEOUT(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_read     (req_read),
    .req_write    (req_write),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .mem_stall    (mem_stall),
    .rdata        (rdata),
    .done         (done),
    .misalign_err (misalign_err),
    .timeout_err  (timeout_err),
    .sram_req     (sram_req),
    .sram_we      (sram_we),
    .sram_addr    (sram_addr),
    .sram_be      (sram_be),
    .sram_wdata   (sram_wdata),
    .sram_ack     (sram_ack),
    .sram_rdata   (sram_rdata)
  );

  task automatic idle_inputs();
    req_read = 0; req_write = 0; req_addr = 0; req_wdata = 0;
    req_size = 0; req_unsigned = 0; sram_ack = 0; sram_rdata = 0;
  endtask

  // Drives one request until done (bounded), acking after ack_lat SRAM-request cycles
  // (0 = never ack). Inputs and outputs are sampled at the falling edge.
  task automatic run_access(input logic rd, input logic wr, input logic [31:0] addr,
                            input logic [31:0] wdat, input logic [1:0] size,
                            input logic uns, input int ack_lat, input logic [31:0] ack_data,
                            output int stalls, output int req_cyc, output int done_cyc,
                            output logic [31:0] rd_o, output logic mis, output logic tmo,
                            output logic [3:0] be, output logic we, output logic [31:0] swd,
                            output logic [29:0] sa, output logic done_after);
    stalls = 0; req_cyc = 0; done_cyc = -1; rd_o = 'x; mis = 0; tmo = 0;
    be = 0; we = 0; swd = 0; sa = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      req_read = rd; req_write = wr; req_addr = addr; req_wdata = wdat;
      req_size = size; req_unsigned = uns; sram_ack = 0;
      #1;
      if (sram_req) begin
        req_cyc++;
        if (req_cyc == 1) begin be = sram_be; we = sram_we; swd = sram_wdata; sa = sram_addr; end
        if (req_cyc == ack_lat) begin sram_ack = 1; sram_rdata = ack_data; end
      end
      #1;
      stalls += int'(mem_stall);
      if (done) begin
        done_cyc = c; rd_o = rdata; mis = misalign_err; tmo = timeout_err;
        break;
      end
    end
    @(negedge clk);
    idle_inputs();
    #1;
    done_after = done | sram_req;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1;
    repeat (2) @(negedge clk);
    #1;
    if ({done, sram_req, sram_we, sram_be, mem_stall} !== 8'b0) begin
      $display("FAIL reset_ctrl: got %b expected 0", {done, sram_req, sram_we, sram_be, mem_stall});
      n_fail++;
    end
    n_checks++;
    if (rdata !== 32'h0) begin $display("FAIL reset_rdata: got %h expected 0", rdata); n_fail++; end
    n_checks++;
    @(negedge clk); rst = 0;
  endtask

  task automatic test_lw();
    int st, rc, dc; logic [31:0] r, wd; logic m, t, w, da; logic [3:0] b; logic [29:0] a;
    run_access(1, 0, 32'h100, 0, 2'b10, 0, 3, 32'h8000_00FF, st, rc, dc, r, m, t, b, w, wd, a, da);
    if (st !== 4 || dc !== 4) begin
      $display("FAIL lw_stall: stalls %0d done_cyc %0d expected 4 4", st, dc); n_fail++;
    end
    n_checks++;
    if (r !== 32'h8000_00FF || m || t) begin
      $display("FAIL lw_data: got %h m%b t%b expected 800000ff", r, m, t); n_fail++;
    end
    n_checks++;
    if (a !== 30'h40 || b !== 4'hF || w !== 0) begin
      $display("FAIL lw_port: addr %h be %b we %b expected 40 1111 0", a, b, w); n_fail++;
    end
    n_checks++;
    if (da !== 0) begin $display("FAIL lw_done_pulse: got %b expected 0", da); n_fail++; end
    n_checks++;
  endtask

  task automatic test_load_ext();
    int st, rc, dc; logic [31:0] r, wd; logic m, t, w, da; logic [3:0] b; logic [29:0] a;
    // lb signed, minimum latency
    run_access(1, 0, 32'h103, 0, 2'b00, 0, 1, 32'h80AB_CDEF, st, rc, dc, r, m, t, b, w, wd, a, da);
    if (r !== 32'hFFFF_FF80 || b !== 4'b1000) begin
      $display("FAIL lb: got %h be %b expected ffffff80 1000", r, b); n_fail++;
    end
    n_checks++;
    if (st !== 2 || dc !== 2) begin
      $display("FAIL min_latency: stalls %0d done_cyc %0d expected 2 2", st, dc); n_fail++;
    end
    n_checks++;
    run_access(1, 0, 32'h103, 0, 2'b00, 1, 1, 32'h80AB_CDEF, st, rc, dc, r, m, t, b, w, wd, a, da);
    if (r !== 32'h0000_0080) begin $display("FAIL lbu: got %h expected 00000080", r); n_fail++; end
    n_checks++;
    run_access(1, 0, 32'h002, 0, 2'b01, 0, 2, 32'hF00D_1234, st, rc, dc, r, m, t, b, w, wd, a, da);
    if (r !== 32'hFFFF_F00D || b !== 4'b1100) begin
      $display("FAIL lh: got %h be %b expected fffff00d 1100", r, b); n_fail++;
    end
    n_checks++;
    run_access(1, 0, 32'h000, 0, 2'b01, 1, 1, 32'hF00D_9234, st, rc, dc, r, m, t, b, w, wd, a, da);
    if (r !== 32'h0000_9234 || b !== 4'b0011) begin
      $display("FAIL lhu: got %h be %b expected 00009234 0011", r, b); n_fail++;
    end
    n_checks++;
  endtask

  task automatic test_misalign();
    int st, rc, dc; logic [31:0] r, wd; logic m, t, w, da; logic [3:0] b; logic [29:0] a;
    logic [31:0] addrs [3] = '{32'h101, 32'h003, 32'h102};
    logic [1:0]  sizes [3] = '{2'b10, 2'b01, 2'b11};
    for (int i = 0; i < 3; i++) begin
      run_access(1, 0, addrs[i], 0, sizes[i], 0, 1, 32'h1234_5678, st, rc, dc, r, m, t, b, w, wd,
                 a, da);
      if (rc !== 0 || st !== 1 || dc !== 1 || m !== 1 || t !== 0 || r !== 0) begin
        $display("FAIL misalign_%0d: req %0d stalls %0d done_cyc %0d mis %b tmo %b rdata %h expected 0 1 1 1 0 0",
                 i, rc, st, dc, m, t, r);
        n_fail++;
      end
      n_checks++;
    end
  endtask

  task automatic test_timeout();
    int st, rc, dc; logic [31:0] r, wd; logic m, t, w, da; logic [3:0] b; logic [29:0] a;
    run_access(1, 0, 32'h200, 0, 2'b10, 0, 0, 0, st, rc, dc, r, m, t, b, w, wd, a, da);
    if (rc !== 4 || t !== 1 || m !== 0 || r !== 0 || st !== 5) begin
      $display("FAIL timeout: req %0d tmo %b mis %b rdata %h stalls %0d expected 4 1 0 0 5",
               rc, t, m, r, st);
      n_fail++;
    end
    n_checks++;
    // Stray ack while idle must not complete anything.
    @(negedge clk); sram_ack = 1; sram_rdata = 32'hDEAD_BEEF;
    @(negedge clk); sram_ack = 0; #1;
    if (done !== 0 || rdata !== 0) begin
      $display("FAIL stray_ack: done %b rdata %h expected 0 0", done, rdata); n_fail++;
    end
    n_checks++;
  endtask

  task automatic test_reset_mid_access();
    @(negedge clk);
    req_read = 1; req_addr = 32'h300; req_size = 2'b10;
    @(negedge clk); #1;
    if (sram_req !== 1) begin $display("FAIL rst_pre: sram_req %b expected 1", sram_req); n_fail++; end
    n_checks++;
    rst = 1; #1;
    if (sram_req !== 0) begin $display("FAIL rst_drop: sram_req %b expected 0", sram_req); n_fail++; end
    n_checks++;
    idle_inputs();
    @(negedge clk); rst = 0;
    @(negedge clk); #1;
    if (done !== 0) begin $display("FAIL rst_no_done: done %b expected 0", done); n_fail++; end
    n_checks++;
  endtask

`ifdef DMEM_CTRL_WBUF_EN
  task automatic test_wbuf();
    @(negedge clk);
    req_write = 1; req_addr = 32'h400; req_wdata = 32'hCAFE_F00D; req_size = 2'b10;
    #1;
    if (mem_stall !== 0) begin $display("FAIL wb_nostall: stall %b expected 0", mem_stall); n_fail++; end
    n_checks++;
    @(negedge clk);
    req_write = 0; req_read = 1; req_addr = 32'h104; #1;
    if ({done, mem_stall, sram_req, sram_we} !== 4'b1111 || sram_addr !== 30'h100 ||
        sram_wdata !== 32'hCAFE_F00D || sram_be !== 4'hF) begin
      $display("FAIL wb_drain: d/s/r/w %b addr %h wdata %h be %b expected 1111 100 cafef00d 1111",
               {done, mem_stall, sram_req, sram_we}, sram_addr, sram_wdata, sram_be);
      n_fail++;
    end
    n_checks++;
    @(negedge clk); #1;
    sram_ack = 1;
    if (mem_stall !== 1 || sram_we !== 1) begin
      $display("FAIL wb_wait: stall %b we %b expected 1 1", mem_stall, sram_we); n_fail++;
    end
    n_checks++;
    @(negedge clk); sram_ack = 0; #1;
    if (mem_stall !== 1 || sram_req !== 0) begin
      $display("FAIL wb_load_idle: stall %b req %b expected 1 0", mem_stall, sram_req); n_fail++;
    end
    n_checks++;
    @(negedge clk); #1;
    if (sram_req !== 1 || sram_we !== 0 || sram_addr !== 30'h41) begin
      $display("FAIL wb_load_req: req %b we %b addr %h expected 1 0 41", sram_req, sram_we, sram_addr);
      n_fail++;
    end
    n_checks++;
    sram_ack = 1; sram_rdata = 32'h1122_3344;
    @(negedge clk); sram_ack = 0; #1;
    if (done !== 1 || rdata !== 32'h1122_3344 || mem_stall !== 0) begin
      $display("FAIL wb_load_done: done %b rdata %h stall %b expected 1 11223344 0",
               done, rdata, mem_stall);
      n_fail++;
    end
    n_checks++;
    @(negedge clk); idle_inputs();
  endtask
`else
  task automatic test_store();
    int st, rc, dc; logic [31:0] r, wd; logic m, t, w, da; logic [3:0] b; logic [29:0] a;
    run_access(0, 1, 32'h202, 32'hDEAD_1234, 2'b01, 0, 1, 0, st, rc, dc, r, m, t, b, w, wd, a, da);
    if (b !== 4'b1100 || wd !== 32'h1234_1234 || w !== 1 || a !== 30'h80) begin
      $display("FAIL sh: be %b wdata %h we %b addr %h expected 1100 12341234 1 80", b, wd, w, a);
      n_fail++;
    end
    n_checks++;
    if (st !== 2 || dc !== 2) begin
      $display("FAIL sh_latency: stalls %0d done_cyc %0d expected 2 2", st, dc); n_fail++;
    end
    n_checks++;
    run_access(0, 1, 32'h301, 32'h0000_00AB, 2'b00, 0, 2, 0, st, rc, dc, r, m, t, b, w, wd, a, da);
    if (b !== 4'b0010 || wd !== 32'hABAB_ABAB || w !== 1 || rc !== 2) begin
      $display("FAIL sb: be %b wdata %h we %b req %0d expected 0010 abababab 1 2", b, wd, w, rc);
      n_fail++;
    end
    n_checks++;
  endtask
`endif

  initial begin
    test_reset();
    test_lw();
    test_load_ext();
    test_misalign();
    test_timeout();
`ifdef DMEM_CTRL_WBUF_EN
    test_wbuf();
`else
    test_store();
`endif
    test_reset_mid_access();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
